// File: rtl/enemy_pkg.sv
// Shared geometry defaults, FSM state type and cell-position helper for the
// invader formation controller.
package enemy_pkg;

    localparam int unsigned ROWS_DEF      = 2;
    localparam int unsigned COLS_DEF      = 9;
    localparam int unsigned X_MIN_DEF     = 8;
    localparam int unsigned X_MAX_DEF     = 60;
    localparam int unsigned Y_START_DEF   = 10;
    localparam int unsigned SPACING_X_DEF = 28;
    localparam int unsigned SPACING_Y_DEF = 25;
    localparam int unsigned SPRITE_W_DEF  = 20;
    localparam int unsigned SPRITE_H_DEF  = 20;
    localparam int unsigned Y_JUMP_DEF    = 20;
    localparam int unsigned Y_LIMIT_DEF   = 200;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        MOVE,
        DRAW,
        CHECK,
        KILL
    } state_t;

    typedef struct packed {
        logic [31:0] dx;
        logic [31:0] dy;
    } cell_off_t;

    // Pixel offset of a row-major cell index from the formation anchor.
    function automatic cell_off_t cell_xy(input logic [31:0] idx,
                                          input logic [31:0] cols,
                                          input logic [31:0] sx,
                                          input logic [31:0] sy);
        cell_off_t o;
        o.dx = (idx % cols) * sx;
        o.dy = (idx / cols) * sy;
        return o;
    endfunction

endpackage

// File: rtl/enemy_formation_if.sv
// Bullet-check and sprite-plotter handshake bundle of the formation controller.
interface enemy_formation_if #(
    parameter int unsigned X_W = 9,
    parameter int unsigned Y_W = 8
);
    logic           chk_req;
    logic [X_W-1:0] bullet_x;
    logic [Y_W-1:0] bullet_y;
    logic           chk_ack;
    logic           hit;
    logic           draw_req;
    logic [X_W-1:0] draw_x;
    logic [Y_W-1:0] draw_y;
    logic           draw_erase;
    logic           draw_done;

    modport master (
        output chk_req, bullet_x, bullet_y, draw_done,
        input  chk_ack, hit, draw_req, draw_x, draw_y, draw_erase
    );

    modport slave (
        input  chk_req, bullet_x, bullet_y, draw_done,
        output chk_ack, hit, draw_req, draw_x, draw_y, draw_erase
    );
endinterface

// File: rtl/enemy_formation_next_alive_finder.sv
// Combinational priority encoder: lowest alive index at or above start.
module next_alive_finder
    import enemy_pkg::*;
#(
    parameter int unsigned N     = 18,
    parameter int unsigned IDX_W = 5
) (
    input  logic [N-1:0]   alive,
    input  logic [IDX_W:0] start,
    output logic [IDX_W-1:0] idx,
    output logic           none
);

    always_comb begin
        idx  = '0;
        none = 1'b1;
        // Descending walk so the lowest qualifying index is written last.
        for (int unsigned i = N; i > 0; i--) begin
            if (alive[i-1] && ((i - 1) >= 32'(start))) begin
                idx  = IDX_W'(i - 1);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/enemy_formation.sv
// Invader grid controller: alive map, marching anchor, bullet hit scan, score,
// and erase/redraw sequencing towards the sprite plotter.
module enemy_formation
    import enemy_pkg::*;
#(
    parameter int unsigned ROWS      = ROWS_DEF,
    parameter int unsigned COLS      = COLS_DEF,
    parameter int unsigned X_W       = 9,
    parameter int unsigned Y_W       = 8,
    parameter int unsigned X_MIN     = X_MIN_DEF,
    parameter int unsigned X_MAX     = X_MAX_DEF,
    parameter int unsigned Y_START   = Y_START_DEF,
    parameter int unsigned SPACING_X = SPACING_X_DEF,
    parameter int unsigned SPACING_Y = SPACING_Y_DEF,
    parameter int unsigned SPRITE_W  = SPRITE_W_DEF,
    parameter int unsigned SPRITE_H  = SPRITE_H_DEF,
    parameter int unsigned Y_JUMP    = Y_JUMP_DEF,
    parameter int unsigned Y_LIMIT   = Y_LIMIT_DEF,
    parameter int unsigned STEP_DIV  = 3,
    parameter int unsigned SCORE_W   = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tick,
    enemy_formation_if.slave                bus,
    output logic                            busy,
    output logic [$clog2(ROWS*COLS+1)-1:0]  alive_count,
    output logic [SCORE_W-1:0]              score,
    output logic                            all_dead,
    output logic                            invaded
);

    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned YB_W  = Y_W + 2;

    state_t           state;
    logic [N-1:0]     alive;
    logic [X_W-1:0]   anchor_x;
    logic [Y_W-1:0]   anchor_y;
    logic             dir_left;
    logic [DIV_W-1:0] div_cnt;
    logic             tick_pending;
    logic [IDX_W:0]   scan_ptr;

    logic [IDX_W-1:0] fa_idx;
    logic             fa_none;

    next_alive_finder #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_finder (
        .alive (alive),
        .start (scan_ptr),
        .idx   (fa_idx),
        .none  (fa_none)
    );

    cell_off_t      off;
    logic [31:0]    cell_x_full;
    logic [31:0]    cell_y_full;
    logic [X_W-1:0] cell_x;
    logic [Y_W-1:0] cell_y;
    logic           cell_hit;

    always_comb begin
        off         = cell_xy(32'(fa_idx), COLS, SPACING_X, SPACING_Y);
        cell_x_full = 32'(anchor_x) + off.dx;
        cell_y_full = 32'(anchor_y) + off.dy;
        cell_x      = X_W'(cell_x_full);
        cell_y      = Y_W'(cell_y_full);
        cell_hit    = !fa_none
                   && (32'(bus.bullet_x) >= cell_x_full)
                   && (32'(bus.bullet_x) <= cell_x_full + SPRITE_W - 1)
                   && (32'(bus.bullet_y) >= cell_y_full)
                   && (32'(bus.bullet_y) <= cell_y_full + SPRITE_H - 1);
    end

    logic           at_edge;
    logic [X_W-1:0] next_x;
    logic [Y_W-1:0] next_y;
    logic           next_left;
    logic [YB_W-1:0] bottom;

    always_comb begin
        at_edge   = dir_left ? (anchor_x <= X_W'(X_MIN)) : (anchor_x >= X_W'(X_MAX));
        next_x    = anchor_x;
        next_y    = anchor_y;
        next_left = dir_left;
        if (at_edge) begin
            next_y    = anchor_y + Y_W'(Y_JUMP);
            next_left = !dir_left;
        end else if (dir_left) begin
            next_x = anchor_x - X_W'(1);
        end else begin
            next_x = anchor_x + X_W'(1);
        end
        // Widened so a formation near the bottom cannot wrap past the limit.
        bottom = YB_W'(next_y) + YB_W'((ROWS - 1) * SPACING_Y + SPRITE_H);
    end

    logic [CNT_W-1:0] live_n;

    always_comb begin
        live_n = '0;
        for (int unsigned i = 0; i < N; i++) begin
            live_n = live_n + CNT_W'(alive[i]);
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            alive          <= '1;
            anchor_x       <= X_W'(X_MIN);
            anchor_y       <= Y_W'(Y_START);
            dir_left       <= 1'b0;
            div_cnt        <= '0;
            tick_pending   <= 1'b0;
            scan_ptr       <= '0;
            bus.draw_req   <= 1'b0;
            bus.draw_x     <= '0;
            bus.draw_y     <= '0;
            bus.draw_erase <= 1'b0;
            bus.chk_ack    <= 1'b0;
            bus.hit        <= 1'b0;
            score          <= '0;
            alive_count    <= CNT_W'(N);
            all_dead       <= 1'b0;
            invaded        <= 1'b0;
        end else begin
            bus.chk_ack <= 1'b0;
            bus.hit     <= 1'b0;
            alive_count <= live_n;
            all_dead    <= (live_n == '0);

            case (state)
                IDLE: begin
                    scan_ptr <= '0;
                    if (bus.chk_req) begin
                        state <= CHECK;
                    end else if (tick_pending && !all_dead && !invaded) begin
                        tick_pending <= 1'b0;
                        if (div_cnt == DIV_W'(STEP_DIV - 1)) begin
                            div_cnt <= '0;
                            if (!fa_none) begin
                                state          <= ERASE;
                                bus.draw_req   <= 1'b1;
                                bus.draw_x     <= cell_x;
                                bus.draw_y     <= cell_y;
                                bus.draw_erase <= 1'b1;
                                scan_ptr       <= {1'b0, fa_idx} + (IDX_W+1)'(1);
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                end

                // While a request is held, scan_ptr already points past it, so
                // the finder presents the following cell for the done cycle.
                ERASE, DRAW: begin
                    if (!bus.draw_req || bus.draw_done) begin
                        if (fa_none) begin
                            bus.draw_req <= 1'b0;
                            scan_ptr     <= '0;
                            state        <= (state == ERASE) ? MOVE : IDLE;
                        end else begin
                            bus.draw_req   <= 1'b1;
                            bus.draw_x     <= cell_x;
                            bus.draw_y     <= cell_y;
                            bus.draw_erase <= (state == ERASE);
                            scan_ptr       <= {1'b0, fa_idx} + (IDX_W+1)'(1);
                        end
                    end
                end

                MOVE: begin
                    anchor_x <= next_x;
                    anchor_y <= next_y;
                    dir_left <= next_left;
                    if (bottom >= YB_W'(Y_LIMIT)) invaded <= 1'b1;
                    scan_ptr <= '0;
                    state    <= DRAW;
                end

                CHECK: begin
                    if (fa_none) begin
                        bus.chk_ack <= 1'b1;
                        bus.hit     <= 1'b0;
                        scan_ptr    <= '0;
                        state       <= IDLE;
                    end else if (cell_hit) begin
                        alive[fa_idx]  <= 1'b0;
                        if (score != '1) score <= score + SCORE_W'(1);
                        bus.draw_req   <= 1'b1;
                        bus.draw_x     <= cell_x;
                        bus.draw_y     <= cell_y;
                        bus.draw_erase <= 1'b1;
                        state          <= KILL;
                    end else begin
                        scan_ptr <= {1'b0, fa_idx} + (IDX_W+1)'(1);
                    end
                end

                KILL: begin
                    if (bus.draw_done) begin
                        bus.draw_req <= 1'b0;
                        bus.chk_ack  <= 1'b1;
                        bus.hit      <= 1'b1;
                        scan_ptr     <= '0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase

            if (tick) tick_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_enemy_formation.sv
// Directed scoreboard bench for enemy_formation with a 4-cycle plotter responder.
module tb_enemy_formation;

    localparam int COLS = 9;
    localparam int N    = 18;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic       busy;
    logic [4:0] alive_count;
    logic [4:0] score;
    logic       all_dead;
    logic       invaded;

    enemy_formation_if #(.X_W(9), .Y_W(8)) bus();

    enemy_formation #(.STEP_DIV(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .bus         (bus),
        .busy        (busy),
        .alive_count (alive_count),
        .score       (score),
        .all_dead    (all_dead),
        .invaded     (invaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic       erase;
    } dreq_t;

    dreq_t dq[$];
    bit    exp_hit_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_req = 0;

    int ax, ay, m_score;
    bit left;
    bit m_alive[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic dreq_t cell_req(input int i, input bit erase);
        dreq_t d;
        d.x     = 9'(ax + (i % COLS) * 28);
        d.y     = 8'(ay + (i / COLS) * 25);
        d.erase = erase;
        return d;
    endfunction

    function automatic int model_hit(input int bx, input int by);
        for (int i = 0; i < N; i++) begin
            int x, y;
            x = ax + (i % COLS) * 28;
            y = ay + (i / COLS) * 25;
            if (m_alive[i] && bx >= x && bx <= x + 19 && by >= y && by <= y + 19) return i;
        end
        return -1;
    endfunction

    // Plotter: answers each request with draw_done four cycles later.
    initial begin
        int cnt;
        dreq_t got, e;
        cnt = 0;
        bus.draw_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                bus.draw_done = 1'b0;
                cnt = 0;
                dq.delete();
            end else begin
                if (bus.draw_done) begin
                    bus.draw_done = 1'b0;
                    cnt = 0;
                end
                if (bus.draw_req) begin
                    if (cnt == 0) begin
                        n_req++;
                        got = '{x: bus.draw_x, y: bus.draw_y, erase: bus.draw_erase};
                        check("draw_req_expected", 32'(dq.size() != 0), 1);
                        if (dq.size() != 0) begin
                            e = dq.pop_front();
                            check("draw_cell", 32'(got), 32'(e));
                        end
                    end
                    cnt++;
                    if (cnt == 4) bus.draw_done = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        ax = 8; ay = 10; left = 1'b0; m_score = 0;
        for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
        exp_hit_q.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        model_reset();
        cyc(1);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic push_step();
        for (int i = 0; i < N; i++) if (m_alive[i]) dq.push_back(cell_req(i, 1'b1));
        if (!left && ax == 60) begin ay += 20; left = 1'b1; end
        else if (left && ax == 8) begin ay += 20; left = 1'b0; end
        else if (left) ax--;
        else ax++;
        for (int i = 0; i < N; i++) if (m_alive[i]) dq.push_back(cell_req(i, 1'b0));
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        cyc(2);
        for (int i = 0; i < 1500 && !done; i++) begin
            cyc(1);
            if (!busy) done = 1'b1;
        end
        check("idle_timeout", 32'(done), 1);
        check("queue_drained", 32'(dq.size()), 0);
    endtask

    task automatic do_step();
        push_step();
        pulse_tick();
        wait_idle();
    endtask

    task automatic do_chk(input int bx, input int by, input bit with_tick);
        int h;
        bit got, exp;
        h = model_hit(bx, by);
        exp_hit_q.push_back(h >= 0);
        if (h >= 0) begin
            dq.push_back(cell_req(h, 1'b1));
            m_alive[h] = 1'b0;
            m_score++;
        end
        bus.bullet_x = 9'(bx);
        bus.bullet_y = 8'(by);
        bus.chk_req  = 1'b1;
        if (with_tick) tick = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            cyc(1);
            tick = 1'b0;
            if (bus.chk_ack) got = 1'b1;
        end
        bus.chk_req = 1'b0;
        check("chk_ack_timeout", 32'(got), 1);
        if (got) begin
            exp = exp_hit_q.pop_front();
            check("hit", 32'(bus.hit), 32'(exp));
        end else begin
            exp_hit_q.delete();
        end
        check("kill_erase_drained", 32'(dq.size()), 0);
    endtask

    initial begin
        int base;
        bit ok;
        bus.chk_req  = 1'b0;
        bus.bullet_x = '0;
        bus.bullet_y = '0;
        model_reset();
        cyc(3);
        reset = 1'b0;
        cyc(1);

        check("rst_draw_req", 32'(bus.draw_req), 0);
        check("rst_chk_ack", 32'(bus.chk_ack), 0);
        check("rst_hit", 32'(bus.hit), 0);
        check("rst_invaded", 32'(invaded), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_alive_count", 32'(alive_count), 18);
        check("rst_score", 32'(score), 0);
        check("rst_all_dead", 32'(all_dead), 0);

        // Three marching steps, then run to the right edge and turn.
        for (int s = 0; s < 3; s++) begin
            base = n_req;
            do_step();
            check("step_req_count", 32'(n_req - base), 36);
        end
        while (ax != 60) do_step();
        do_step();
        do_step();

        // Bullet scenarios from a fresh formation.
        apply_reset();
        base = n_req;
        do_chk(36, 40, 1'b0);
        cyc(2);
        check("score_after_kill", 32'(score), 1);
        check("alive_after_kill", 32'(alive_count), 17);
        check("one_erase_req", 32'(n_req - base), 1);
        base = n_req;
        do_chk(36, 40, 1'b0);
        check("repeat_no_req", 32'(n_req - base), 0);
        base = n_req;
        do_chk(30, 12, 1'b0);
        check("gap_no_req", 32'(n_req - base), 0);
        check("gap_score", 32'(score), 1);

        // Tick and check together: check first, step afterwards.
        do_chk(10, 12, 1'b1);
        push_step();
        wait_idle();
        check("score_two", 32'(score), 2);

        // Reset while the redraw phase is under way.
        push_step();
        base = n_req;
        pulse_tick();
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            cyc(1);
            if (n_req >= base + 18) ok = 1'b1;
        end
        check("reach_draw_timeout", 32'(ok), 1);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        check("rst_mid_draw_req", 32'(bus.draw_req), 0);
        check("rst_mid_busy", 32'(busy), 0);
        cyc(1);
        reset = 1'b0;
        model_reset();
        cyc(1);
        check("rst_mid_alive", 32'(alive_count), 18);
        check("rst_mid_score", 32'(score), 0);
        do_step();

        // Destroy the whole formation.
        for (int i = 0; i < N; i++) do_chk(ax + (i % COLS) * 28 + 3, ay + (i / COLS) * 25 + 3, 1'b0);
        cyc(2);
        check("dead_alive_count", 32'(alive_count), 0);
        check("dead_all_dead", 32'(all_dead), 1);
        check("dead_score", 32'(score), 18);
        base = n_req;
        for (int t = 0; t < 3; t++) begin
            pulse_tick();
            cyc(3);
        end
        cyc(20);
        check("dead_no_draw", 32'(n_req - base), 0);
        check("dead_busy", 32'(busy), 0);
        do_chk(100, 50, 1'b0);
        check("dead_score_hold", 32'(score), 18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
